// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: writeback and forward
// encodings, the shadow-pipeline tag and the sequencing FSM states.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        WB_LOAD = 2'b00,
        WB_ALU  = 2'b01,
        WB_PC   = 2'b10
    } wbsel_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_PC  = 2'b11
    } fwd_e;

    // Destination half of a tag; this is all that MEM and WB need to keep.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwen;
        wbsel_e            wbsel;
    } hz_dst_t;

    // Full tag carried into EX: destination plus the sources it reads.
    typedef struct packed {
        hz_dst_t           dst;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use1;
        logic              use2;
    } hz_tag_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_BUBBLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

    // A stage can supply a value only if it really writes a non-zero register.
    function automatic logic dst_writes(hz_dst_t d);
        return d.valid && d.regwen && (d.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forward selector for one EX source: compares the EX source register
// against the MEM and WB destinations, youngest producer first.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic              src_valid,
    input  logic              src_use,
    input  logic [REG_AW-1:0] src_rs,
    input  hz_dst_t           mem_dst,
    input  hz_dst_t           wb_dst,
    output fwd_e              fwdsel,
    output logic              pcsel,
    output logic              load_hit
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = src_valid && src_use && dst_writes(mem_dst) && (mem_dst.rd == src_rs);
    assign wb_hit  = src_valid && src_use && dst_writes(wb_dst)  && (wb_dst.rd  == src_rs);

    // Pick the operand source; MEM beats WB because it holds the newer value.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        fwdsel   = FWD_REG;
        pcsel    = 1'b0;
        load_hit = 1'b0;
        if (mem_hit) begin
            fwdsel   = (mem_dst.wbsel == WB_PC) ? FWD_PC : FWD_MEM;
            load_hit = (mem_dst.wbsel == WB_LOAD);
        end else if (wb_hit) begin
            if (wb_dst.wbsel == WB_PC) begin
                fwdsel = FWD_PC;
                pcsel  = 1'b1;
            end else begin
                fwdsel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline. Shadows the
// destination tags of EX/MEM/WB, drives the EX operand muxes and sequences
// load-use bubbles, redirect flushes and memory-busy holds.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W  = REG_AW,   // must equal REG_AW; tags are sized by the package
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwen,
    input  logic [1:0]       id_wbsel,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic [1:0]       fwdselA,
    output logic [1:0]       fwdselB,
    output logic             pcselA,
    output logic             pcselB,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_tag_t id_tag;
    hz_tag_t ex_tag;
    hz_dst_t mem_dst;
    hz_dst_t wb_dst;
    state_e  state;

    logic load_use;
    logic take_bubble;
    fwd_e fwd_a;
    fwd_e fwd_b;
    logic load_hit_a;
    logic load_hit_b;

    // Pack the ID-stage fields into a tag.
    always_comb begin
        id_tag.dst.valid  = id_valid;
        id_tag.dst.rd     = id_rd;
        id_tag.dst.regwen = id_regwen;
        id_tag.dst.wbsel  = wbsel_e'(id_wbsel);
        id_tag.rs1        = id_rs1;
        id_tag.rs2        = id_rs2;
        id_tag.use1       = id_use1;
        id_tag.use2       = id_use2;
    end

    // Load in EX whose result the ID instruction needs next cycle.
    assign load_use = id_valid
                   && dst_writes(ex_tag.dst) && (ex_tag.dst.wbsel == WB_LOAD)
                   && ((id_use1 && (id_rs1 == ex_tag.dst.rd)) ||
                       (id_use2 && (id_rs2 == ex_tag.dst.rd)));

    // Pipeline control; priority is memory busy, then redirect, then load-use.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        take_bubble = 1'b0;
        // Gated by rst_n so every control reads 0 the moment reset is applied.
        if (rst_n) begin
            if (dmem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else if (ex_redirect) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (load_use && (state != ST_BUBBLE)) begin
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                flush_ex    = 1'b1;
                take_bubble = 1'b1;
            end
        end
    end

    // Sequencing FSM: remembers an inserted bubble and an active memory hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_busy)        state <= ST_HOLD;
                    else if (take_bubble) state <= ST_BUBBLE;
                end
                ST_BUBBLE: state <= dmem_busy ? ST_HOLD : ST_RUN;
                ST_HOLD: begin
                    if (!dmem_busy) state <= take_bubble ? ST_BUBBLE : ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Shadow pipeline of tags; frozen while EX is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag  <= '0;
            mem_dst <= '0;
            wb_dst  <= '0;
        end else if (!stall_ex) begin
            ex_tag  <= (flush_ex || !id_valid) ? '0 : id_tag;
            mem_dst <= ex_tag.dst;
            wb_dst  <= mem_dst;
        end
    end

    // Performance counters; they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall_if};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, flush_id};
        end
    end

    fwd_sel u_fwd_a (
        .src_valid (ex_tag.dst.valid),
        .src_use   (ex_tag.use1),
        .src_rs    (ex_tag.rs1),
        .mem_dst   (mem_dst),
        .wb_dst    (wb_dst),
        .fwdsel    (fwd_a),
        .pcsel     (pcselA),
        .load_hit  (load_hit_a)
    );

    fwd_sel u_fwd_b (
        .src_valid (ex_tag.dst.valid),
        .src_use   (ex_tag.use2),
        .src_rs    (ex_tag.rs2),
        .mem_dst   (mem_dst),
        .wb_dst    (wb_dst),
        .fwdsel    (fwd_b),
        .pcsel     (pcselB),
        .load_hit  (load_hit_b)
    );

    assign fwdselA = fwd_a;
    assign fwdselB = fwd_b;

    // A load result is never in MEM when its consumer is in EX; the bubble prevents it.
    ast_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
        !(load_hit_a || load_hit_b));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// instruction streams compared against an instruction-level pipeline model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use1, id_use2, id_regwen;
    logic [1:0]  id_wbsel;
    logic        ex_redirect, dmem_busy;
    logic [1:0]  fwdselA, fwdselB;
    logic        pcselA, pcselB;
    logic        stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rd(id_rd), .id_regwen(id_regwen), .id_wbsel(id_wbsel),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .fwdselA(fwdselA), .fwdselB(fwdselB), .pcselA(pcselA), .pcselB(pcselB),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Instruction as the model sees it; wb: 0 load, 1 ALU, 2 PC+4.
    typedef struct {
        bit valid;
        int rd;
        bit regwen;
        int wb;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } instr_t;

    instr_t m_ex, m_mem, m_wb, cur;
    bit cur_redir, cur_busy, primed;
    bit e_sif, e_sid, e_sex, e_fid, e_fex, e_pa, e_pb;
    int e_fa, e_fb;
    int unsigned m_scnt, m_fcnt;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic instr_t mk(int wb, int rd, int rs1, bit u1, int rs2, bit u2);
        instr_t i;
        i = '{valid: 1'b1, rd: rd, regwen: 1'b1, wb: wb, rs1: rs1, rs2: rs2, u1: u1, u2: u2};
        return i;
    endfunction

    // Does instruction p deliver a usable value for register r?
    function automatic bit produces(instr_t p, int r);
        return p.valid && p.regwen && (p.rd != 0) && (p.rd == r);
    endfunction

    task automatic operand_exp(input int rs, input bit u, output int sel, output bit pc);
        sel = 0;
        pc  = 1'b0;
        if (m_ex.valid && u) begin
            if (produces(m_mem, rs)) sel = (m_mem.wb == 2) ? 3 : 2;
            else if (produces(m_wb, rs)) begin
                sel = (m_wb.wb == 2) ? 3 : 1;
                pc  = (m_wb.wb == 2);
            end
        end
    endtask

    task automatic compute_exp();
        bit lu;
        operand_exp(m_ex.rs1, m_ex.u1, e_fa, e_pa);
        operand_exp(m_ex.rs2, m_ex.u2, e_fb, e_pb);
        lu = cur.valid && m_ex.valid && (m_ex.wb == 0) &&
             ((cur.u1 && produces(m_ex, cur.rs1)) || (cur.u2 && produces(m_ex, cur.rs2)));
        {e_sif, e_sid, e_sex, e_fid, e_fex} = '0;
        if (cur_busy)       {e_sif, e_sid, e_sex} = 3'b111;
        else if (cur_redir) {e_fid, e_fex} = 2'b11;
        else if (lu)        {e_sif, e_sid, e_fex} = 3'b111;
    endtask

    task automatic update_model();
        m_scnt += 32'(e_sif);
        m_fcnt += 32'(e_fid);
        if (!e_sex) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e_fex || !cur.valid) ? nop() : cur;
        end
    endtask

    task automatic check_all();
        check("fwdselA", 32'(fwdselA), 32'(e_fa));
        check("fwdselB", 32'(fwdselB), 32'(e_fb));
        check("pcselA", 32'(pcselA), 32'(e_pa));
        check("pcselB", 32'(pcselB), 32'(e_pb));
        check("stalls", 32'({stall_if, stall_id, stall_ex}), 32'({e_sif, e_sid, e_sex}));
        check("flushes", 32'({flush_id, flush_ex}), 32'({e_fid, e_fex}));
        check("stall_cnt", stall_cnt, m_scnt);
        check("flush_cnt", flush_cnt, m_fcnt);
    endtask

    task automatic drive();
        id_valid    = cur.valid;
        id_rd       = 5'(cur.rd);
        id_regwen   = cur.regwen;
        id_wbsel    = 2'(cur.wb);
        id_rs1      = 5'(cur.rs1);
        id_rs2      = 5'(cur.rs2);
        id_use1     = cur.u1;
        id_use2     = cur.u2;
        ex_redirect = cur_redir;
        dmem_busy   = cur_busy;
    endtask

    // One cycle: retire the previous edge into the model, drive new inputs, compare.
    task automatic step(input instr_t id, input bit redir, input bit busy);
        @(posedge clk);
        #1;
        if (primed) update_model();
        primed = 1'b1;
        @(negedge clk);
        cur       = id;
        cur_redir = redir;
        cur_busy  = busy;
        drive();
        #1;
        compute_exp();
        check_all();
    endtask

    // Apply reset with the current inputs still driven, check outputs clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_fwd"}, 32'({fwdselA, fwdselB, pcselA, pcselB}), 32'd0);
        check({tag, "_ctl"}, 32'({stall_if, stall_id, stall_ex, flush_id, flush_ex}), 32'd0);
        check({tag, "_cnt"}, stall_cnt | flush_cnt, 32'd0);
        cur = nop();
        cur_redir = 1'b0;
        cur_busy  = 1'b0;
        drive();
        m_ex = nop(); m_mem = nop(); m_wb = nop();
        m_scnt = 0; m_fcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        primed = 1'b0;
    endtask

    initial begin
        instr_t nx;
        bit redir, busy;
        primed = 1'b0;
        cur = nop(); cur_redir = 1'b0; cur_busy = 1'b0;
        drive();
        do_reset("reset");

        // Back-to-back ALU dependency forwards from MEM on both operands.
        step(mk(1, 1, 0, 1, 0, 0), 0, 0);
        step(mk(1, 2, 1, 1, 1, 1), 0, 0);
        step(nop(), 0, 0);
        check("t1_fwdA", 32'(fwdselA), 32'd2);
        check("t1_fwdB", 32'(fwdselB), 32'd2);
        check("t1_nostall", 32'(stall_if), 32'd0);

        // One gap forwards from WB; two writers of x3 pick MEM.
        step(mk(1, 3, 0, 0, 0, 0), 0, 0);
        step(nop(), 0, 0);
        step(mk(1, 4, 3, 1, 0, 0), 0, 0);
        step(nop(), 0, 0);
        check("t2_wb", 32'(fwdselA), 32'd1);
        step(mk(1, 3, 0, 0, 0, 0), 0, 0);
        step(mk(1, 3, 0, 0, 0, 0), 0, 0);
        step(mk(1, 4, 3, 1, 0, 0), 0, 0);
        step(nop(), 0, 0);
        check("t2_mem_wins", 32'(fwdselA), 32'd2);

        // Load-use: one bubble, then forward from WB.
        do_reset("rst3");
        step(mk(0, 5, 1, 1, 0, 0), 0, 0);
        step(mk(1, 6, 5, 1, 0, 1), 0, 0);
        check("t3_bubble", 32'({stall_if, stall_id, flush_ex}), 32'b111);
        step(mk(1, 6, 5, 1, 0, 1), 0, 0);
        check("t3_once", 32'(stall_if), 32'd0);
        step(nop(), 0, 0);
        check("t3_fwdA", 32'(fwdselA), 32'd1);
        check("t3_stall_cnt", stall_cnt, 32'd1);

        // Link register forwarding from MEM then WB.
        do_reset("rst4");
        step(mk(2, 1, 0, 0, 0, 0), 0, 0);
        step(mk(1, 2, 1, 1, 0, 0), 0, 0);
        step(nop(), 0, 0);
        check("t4_pc_mem", 32'({fwdselA, pcselA}), 32'b110);
        step(mk(2, 1, 0, 0, 0, 0), 0, 0);
        step(nop(), 0, 0);
        step(mk(1, 2, 1, 1, 0, 0), 0, 0);
        step(nop(), 0, 0);
        check("t4_pc_wb", 32'({fwdselA, pcselA}), 32'b111);

        // Redirect beats a coincident load-use.
        do_reset("rst5");
        step(mk(0, 5, 1, 1, 0, 0), 0, 0);
        step(mk(1, 6, 5, 1, 0, 1), 1, 0);
        check("t5_flush", 32'({flush_id, flush_ex, stall_if}), 32'b110);
        step(nop(), 0, 0);
        check("t5_flush_cnt", flush_cnt, 32'd1);

        // Memory busy for 3 cycles with a redirect pending.
        do_reset("rst6");
        step(mk(1, 7, 0, 0, 0, 0), 0, 0);
        step(mk(1, 8, 7, 1, 0, 0), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(nop(), 1, 1);
            check("t6_hold", 32'({stall_if, stall_id, stall_ex, flush_id}), 32'b1110);
            check("t6_frozen", 32'(fwdselA), 32'd2);
        end
        step(nop(), 1, 0);
        check("t6_late_flush", 32'({flush_id, flush_ex, stall_if}), 32'b110);
        step(nop(), 0, 0);
        check("t6_cnts", {stall_cnt[15:0], flush_cnt[15:0]}, {16'd3, 16'd1});
        step(nop(), 0, 1);
        step(nop(), 0, 1);
        do_reset("mid_hold");

        // Writes to x0 never forward.
        step(mk(1, 0, 1, 1, 2, 1), 0, 0);
        step(mk(1, 9, 0, 1, 0, 1), 0, 0);
        step(nop(), 0, 0);
        check("x0_nofwd", 32'({fwdselA, fwdselB}), 32'd0);

        // Randomized streams over a small register set to force frequent hazards.
        do_reset("rst_rand");
        for (int n = 0; n < 3000; n++) begin
            if (e_sid) nx = cur;
            else if (e_fid) nx = nop();
            else begin
                nx = mk(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                nx.valid  = ($urandom_range(0, 9) != 0);
                nx.regwen = ($urandom_range(0, 9) != 0);
            end
            redir = ($urandom_range(0, 11) == 0);
            busy  = ($urandom_range(0, 7) == 0);
            step(nx, redir, busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
